gp_register_bank: RTL
=====================

// Module: gp_register_bank
// PURPOSE
//   Sixteen-entry general-purpose register bank. It sits directly downstream of the 4-to-16 register-select decoder.
//   Consumes that decoder's one-hot outputs as write and read selects. Writes are synchronous.
//   Read data is registered with write-first bypass. Illegal (non-one-hot) selects are trapped as a sticky error.
//   R0 can be forced to read as zero for base-address formation.
// PARAMETERS
//   DATA_W   32  width of each register and of both data ports
//   R0_BA_EN 1   1: ba_out forces R0 reads to zero; 0: ba_out ignored
// PORTS
//   clock      in   1       single clock; all state changes on rising edge
//   clear_n    in   1       asynchronous, active-low reset
//   wr_sel     in   16      one-hot write select from decoder; bit k selects R(15-k)
//   wr_strobe  in   1       write request (Rin) qualifying wr_sel
//   wr_data    in   DATA_W  write data
//   rd_sel     in   16      one-hot read select from decoder; bit k selects R(15-k)
//   rd_strobe  in   1       read request (Rout) qualifying rd_sel
//   ba_out     in   1       base-address mode: a read of R0 returns 0
//   err_clr    in   1       clears sel_err / err_code
//   rd_data    out  DATA_W  registered read data
//   rd_valid   out  1       1-cycle pulse: rd_data holds a legal read result
//   sel_err    out  1       sticky: a strobe arrived with zero or multiple select bits set
//   err_code   out  2       01 = write select illegal, 10 = read select illegal, 11 = both in one cycle; sticky
// BEHAVIOUR
//   Reset (clear_n=0, async)
//     - All 16 registers go to 0; rd_data=0, rd_valid=0, sel_err=0, err_code=00.
//     - Reset mid-operation aborts any in-flight write/read. No partial update survives.
//   Write
//     - Legal: wr_strobe=1 and popcount(wr_sel)==1. The register R(15-k) takes wr_data at the rising edge.
//     - Illegal (wr_sel==0 or >1 bits): no register changes. sel_err<=1, err_code[0]<=1.
//     - wr_strobe=0: wr_sel is ignored entirely, with no error check.
//   Read (latency 1)
//     - Legal: rd_strobe=1 and popcount(rd_sel)==1 in cycle N.
//       Then in cycle N+1, rd_data = value of R(15-k) and rd_valid=1 for exactly one cycle.
//     - Bypass: a legal write to the same register in cycle N means rd_data = wr_data in cycle N+1 (write-first).
//     - R0 gating: read of R0 with ba_out=1 and R0_BA_EN=1 gives rd_data=0. This holds even if bypassing a write to R0.
//       R0 storage is still written normally.
//     - Illegal read select: rd_valid=0, rd_data holds its previous value. sel_err<=1, err_code[1]<=1.
//     - rd_strobe=0: rd_valid=0 and rd_data holds.
//   Simultaneous events
//     - Read and write in the same cycle to different registers: both complete independently.
//     - Both selects illegal in one cycle: err_code |= 11.
//     - err_clr with a new error in the same cycle: the new error wins. err_code becomes the new cycle's bits only.
//     - err_clr alone: sel_err<=0, err_code<=00 next edge.
//   No state machine beyond the sticky error flag. Back-to-back strobes every cycle are fully supported (throughput 1/cycle).
// STRUCTURE
//   Shared package cpu_pkg
//     - localparam NREG=16, DATA_W default.
//     - function onehot_legal(16b) -> popcount==1.
//     - function onehot_to_idx(16b) -> 4b register index = 15 - bit position.
//     - typedef err_code_t (2b: NONE, WR, RD, BOTH).
//   One sub-module: onehot_sel_check (16b in -> legal, 4b reg index).
//     - Instantiated twice, once for the write port and once for the read port.
//   Storage is a 16 x DATA_W flop array, not an inferred RAM, because of the async clear.
// TESTING
//   1. Reset then read all: pulse clear_n low.
//      -> Reading each of R0..R15 gives rd_data=0, rd_valid=1 one cycle after each strobe; sel_err=0.
//   2. Write/read map: wr_sel=16'h0001, wr_data=32'hA5A5_0F0F.
//      -> R15 holds the value; rd_sel=16'h0001 returns 32'hA5A5_0F0F.
//      -> rd_sel=16'h8000 (R0) returns 0.
//   3. Bypass: same cycle wr_sel=rd_sel=16'h0010, wr_data=32'h1234_5678.
//      -> Next cycle rd_data=32'h1234_5678, rd_valid=1.
//   4. R0 gating: write R0=32'hFFFF_FFFF, then read R0 with ba_out=1.
//      -> rd_data=0. With ba_out=0 -> rd_data=32'hFFFF_FFFF.
//   5. Illegal selects: wr_strobe with wr_sel=16'h0003.
//      -> R14/R15 are unchanged, sel_err=1, err_code=01.
//      -> Then rd_strobe with rd_sel=0 -> rd_valid=0, err_code=11.
//      -> err_clr -> err_code=00.
//   6. Async reset mid-write: assert clear_n low between clock edges during back-to-back writes.
//      -> All outputs 0 immediately; all registers read 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the register-file slice: sizes, one-hot select helpers
// and the sticky error code encoding.
package cpu_pkg;

  localparam int NREG           = 16;
  localparam int IDX_W          = 4;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_WR   = 2'b01,
    ERR_RD   = 2'b10,
    ERR_BOTH = 2'b11
  } err_code_t;

  function automatic logic onehot_legal(input logic [NREG-1:0] sel);
    return ($countones(sel) == 1);
  endfunction

  // Decoder bit k addresses register R(15-k).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREG-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (sel[i]) idx = IDX_W'(NREG - 1 - i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gp_register_bank_sel_check.sv
// Validates one decoder select vector and converts it to a register index.
module onehot_sel_check
  import cpu_pkg::*;
(
  input  logic [NREG-1:0]  sel,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  assign legal = onehot_legal(sel);
  assign idx   = onehot_to_idx(sel);

endmodule

// File: rtl/gp_register_bank.sv
// Sixteen-entry register bank fed by one-hot decoder selects, with registered
// write-first reads, optional R0-as-zero gating and a sticky select-error trap.
module gp_register_bank
  import cpu_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int R0_BA_EN = 1
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic [NREG-1:0]   wr_sel,
  input  logic              wr_strobe,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NREG-1:0]   rd_sel,
  input  logic              rd_strobe,
  input  logic              ba_out,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sel_err,
  output logic [1:0]        err_code
);

  logic              wr_legal;
  logic              rd_legal;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              wr_en;
  logic              rd_en;
  logic [NREG-1:0]   wr_hit;
  logic [DATA_W-1:0] rd_word_next;
  logic [1:0]        new_err;
  err_code_t         err_code_next;

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [DATA_W-1:0] rd_data_reg;
  logic              rd_valid_reg;
  logic              sel_err_reg;
  err_code_t         err_code_reg;

  onehot_sel_check u_wr_check (
    .sel   (wr_sel),
    .legal (wr_legal),
    .idx   (wr_idx)
  );

  onehot_sel_check u_rd_check (
    .sel   (rd_sel),
    .legal (rd_legal),
    .idx   (rd_idx)
  );

  assign wr_en   = wr_strobe & wr_legal;
  assign rd_en   = rd_strobe & rd_legal;
  assign new_err = {rd_strobe & ~rd_legal, wr_strobe & ~wr_legal};

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_hit
      assign wr_hit[gi] = wr_en && (wr_idx == IDX_W'(gi));
    end
  endgenerate

  // Flop array rather than RAM so the whole bank clears asynchronously.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_hit[i]) regs_reg[i] <= wr_data;
      end
    end
  end

  // Write-first bypass, then R0 gating overrides even a bypassed value.
  always_comb begin
    rd_word_next = regs_reg[rd_idx];
    if (wr_en && (wr_idx == rd_idx)) rd_word_next = wr_data;
    if ((R0_BA_EN != 0) && ba_out && (rd_idx == '0)) rd_word_next = '0;
  end

  // A clear in the same cycle as a new error keeps only this cycle's error bits.
  always_comb begin
    err_code_next = err_clr ? err_code_t'(new_err)
                            : err_code_t'(err_code_reg | new_err);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      sel_err_reg  <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      if (rd_en) rd_data_reg <= rd_word_next;
      rd_valid_reg <= rd_en;
      sel_err_reg  <= (err_code_next != ERR_NONE);
      err_code_reg <= err_code_next;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign sel_err  = sel_err_reg;
  assign err_code = err_code_reg;

endmodule
